// File: rtl/cd_divider_bank.sv
// cd_divider_bank: a bank of independent programmable clock dividers.
// Each channel runs either in toggle mode (50% duty, period 2L) or in pulse
// mode (one-cycle high every L). A new divide value first goes into a
// per-channel shadow register. It becomes active at a period boundary, so a
// running output never sees a truncated or stretched period. While a channel
// still has a shadow value waiting, cfg_ready is low for that channel.
module cd_divider_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_limit,
    input  logic                cfg_mode,
    output logic [CHANNELS-1:0] clkout,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    localparam logic [WIDTH-1:0] LIM_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] LIM_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Active state, shadow state and registered outputs per channel
    logic [WIDTH-1:0]    lim_r    [CHANNELS];
    logic [WIDTH-1:0]    cnt_r    [CHANNELS];
    logic [WIDTH-1:0]    sh_lim_r [CHANNELS];
    logic [CHANNELS-1:0] mode_r;
    logic [CHANNELS-1:0] sh_mode_r;
    logic [CHANNELS-1:0] pend_r;
    logic [CHANNELS-1:0] clkout_r;
    logic [CHANNELS-1:0] tick_r;

    // Next-state values
    logic [WIDTH-1:0]    lim_s    [CHANNELS];
    logic [WIDTH-1:0]    cnt_s    [CHANNELS];
    logic [WIDTH-1:0]    sh_lim_s [CHANNELS];
    logic [CHANNELS-1:0] mode_s;
    logic [CHANNELS-1:0] sh_mode_s;
    logic [CHANNELS-1:0] pend_s;
    logic [CHANNELS-1:0] clkout_s;
    logic [CHANNELS-1:0] tick_s;

    // Per-channel decode
    logic [CHANNELS-1:0] run_s;
    logic [CHANNELS-1:0] wrap_s;
    logic [CHANNELS-1:0] apply_s;
    logic [CHANNELS-1:0] wr_s;
    logic                ready_s;
    logic                accept_s;

    // Write handshake: an out-of-range channel matches no entry and stays ready
    always_comb begin
        ready_s = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            ready_s = (cfg_ch == CH_W'(i)) ? !pend_r[i] : ready_s;
        end
        accept_s = cfg_valid & ready_s;
    end

    // Per-channel run / wrap / apply / write-select decode
    always_comb begin
        run_s   = {CHANNELS{1'b0}};
        wrap_s  = {CHANNELS{1'b0}};
        apply_s = {CHANNELS{1'b0}};
        wr_s    = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            run_s[i]   = en[i] && (lim_r[i] != LIM_ZERO);
            wrap_s[i]  = run_s[i] && (cnt_r[i] >= (lim_r[i] - LIM_ONE));
            // A stopped channel takes its shadow value immediately; a running
            // one waits for the end of its current period.
            apply_s[i] = pend_r[i] && (wrap_s[i] || !run_s[i]);
            wr_s[i]    = accept_s && (cfg_ch == CH_W'(i));
        end
    end

    // Next-state: counter, outputs, shadow capture and shadow apply
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            lim_s[i]     = lim_r[i];
            cnt_s[i]     = cnt_r[i];
            sh_lim_s[i]  = sh_lim_r[i];
            mode_s[i]    = mode_r[i];
            sh_mode_s[i] = sh_mode_r[i];
            pend_s[i]    = pend_r[i];
            clkout_s[i]  = clkout_r[i];
            tick_s[i]    = tick_r[i];

            if (!run_s[i]) begin
                cnt_s[i]    = LIM_ZERO;
                clkout_s[i] = 1'b0;
                tick_s[i]   = 1'b0;
            end else if (wrap_s[i]) begin
                cnt_s[i]  = LIM_ZERO;
                tick_s[i] = 1'b1;
                if (apply_s[i] && (sh_mode_r[i] != mode_r[i])) begin
                    // Mode switch starts the new waveform from a low level
                    clkout_s[i] = 1'b0;
                end else if (mode_r[i]) begin
                    clkout_s[i] = 1'b1;
                end else begin
                    clkout_s[i] = !clkout_r[i];
                end
            end else begin
                cnt_s[i]  = cnt_r[i] + LIM_ONE;
                tick_s[i] = 1'b0;
                if (mode_r[i]) begin
                    clkout_s[i] = 1'b0;
                end else begin
                    clkout_s[i] = clkout_r[i];
                end
            end

            if (apply_s[i]) begin
                lim_s[i]  = sh_lim_r[i];
                mode_s[i] = sh_mode_r[i];
                cnt_s[i]  = LIM_ZERO;
                pend_s[i] = 1'b0;
            end else if (wr_s[i]) begin
                sh_lim_s[i]  = cfg_limit;
                sh_mode_s[i] = cfg_mode;
                pend_s[i]    = 1'b1;
            end else begin
                pend_s[i] = pend_r[i];
            end
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                lim_r[i]    <= LIM_ZERO;
                cnt_r[i]    <= LIM_ZERO;
                sh_lim_r[i] <= LIM_ZERO;
            end
            mode_r    <= {CHANNELS{1'b0}};
            sh_mode_r <= {CHANNELS{1'b0}};
            pend_r    <= {CHANNELS{1'b0}};
            clkout_r  <= {CHANNELS{1'b0}};
            tick_r    <= {CHANNELS{1'b0}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                lim_r[i]    <= lim_s[i];
                cnt_r[i]    <= cnt_s[i];
                sh_lim_r[i] <= sh_lim_s[i];
            end
            mode_r    <= mode_s;
            sh_mode_r <= sh_mode_s;
            pend_r    <= pend_s;
            clkout_r  <= clkout_s;
            tick_r    <= tick_s;
        end
    end

    assign cfg_ready = ready_s;
    assign clkout    = clkout_r;
    assign tick      = tick_r;
    assign pending   = pend_r;

endmodule

// File: tb/tb_cd_divider_bank.sv
// Self-checking bench for cd_divider_bank. It runs three channels so that
// cfg_ch = 3 is an out-of-range channel. A behavioural per-channel model
// follows period lengths, shadow handshakes and output levels, and the DUT
// is compared against it after every clock.
module tb_cd_divider_bank;

    localparam int CH  = 3;
    localparam int W   = 32;
    localparam int CHW = 2;

    logic           clk;
    logic           rst;
    logic [CH-1:0]  en;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [W-1:0]   cfg_limit;
    logic           cfg_mode;
    logic [CH-1:0]  clkout;
    logic [CH-1:0]  tick;
    logic [CH-1:0]  pending;

    int n_checks = 0;
    int n_fail   = 0;

    cd_divider_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_limit(cfg_limit), .cfg_mode(cfg_mode),
        .clkout(clkout), .tick(tick), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model. For each channel it holds the period length, the
    // mode, the cycles elapsed in the current period, the queued update and
    // the output levels.
    int mlen [CH];
    int mage [CH];
    int qlen [CH];
    bit mpul [CH];
    bit qpul [CH];
    bit mq   [CH];
    bit mclk [CH];
    bit mtk  [CH];

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            mlen[i] = 0; mage[i] = 0; qlen[i] = 0;
            mpul[i] = 0; qpul[i] = 0; mq[i] = 0; mclk[i] = 0; mtk[i] = 0;
        end
    endtask

    function automatic bit model_ready();
        if (int'(cfg_ch) >= CH) return 1'b1;
        return !mq[cfg_ch];
    endfunction

    // Move the model across one rising edge, using the inputs present now
    task automatic model_clock();
        bit take;
        bit going;
        bit ends;
        bit swap;
        take = cfg_valid && model_ready() && (int'(cfg_ch) < CH);
        for (int i = 0; i < CH; i++) begin
            going = en[i] && (mlen[i] > 0);
            ends  = going && (mage[i] + 1 >= mlen[i]);
            swap  = mq[i] && (ends || !going);
            if (!going) begin
                mage[i] = 0; mclk[i] = 0; mtk[i] = 0;
            end else if (ends) begin
                mage[i] = 0; mtk[i] = 1;
                if (swap && (qpul[i] != mpul[i])) mclk[i] = 0;
                else if (mpul[i])                 mclk[i] = 1;
                else                              mclk[i] = !mclk[i];
            end else begin
                mage[i] = mage[i] + 1; mtk[i] = 0;
                if (mpul[i]) mclk[i] = 0;
            end
            if (swap) begin
                mlen[i] = qlen[i]; mpul[i] = qpul[i]; mage[i] = 0; mq[i] = 0;
            end else if (take && (int'(cfg_ch) == i)) begin
                qlen[i] = int'(cfg_limit); qpul[i] = cfg_mode; mq[i] = 1;
            end
        end
    endtask

    function automatic logic [CH-1:0] m_clk();
        logic [CH-1:0] r;
        for (int i = 0; i < CH; i++) r[i] = mclk[i];
        return r;
    endfunction

    function automatic logic [CH-1:0] m_tick();
        logic [CH-1:0] r;
        for (int i = 0; i < CH; i++) r[i] = mtk[i];
        return r;
    endfunction

    function automatic logic [CH-1:0] m_pend();
        logic [CH-1:0] r;
        for (int i = 0; i < CH; i++) r[i] = mq[i];
        return r;
    endfunction

    // One clock: advance model, wait for the edge, settle past it
    task automatic cyc();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    // Drive a configuration write, waiting (bounded) until the channel is ready
    task automatic write_cfg(input int ch, input int lim, input bit mode);
        int t;
        t = 0;
        cfg_valid = 1'b0;
        cfg_ch    = ch[CHW-1:0];
        cfg_limit = W'(lim);
        cfg_mode  = mode;
        while (!model_ready() && t < 100) begin
            cyc();
            t++;
        end
        #1;
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL write_ready ch%0d: cfg_ready=%b required 1", ch, cfg_ready);
        end
        cfg_valid = 1'b1;
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        en        = 3'($urandom);
        cfg_valid = 1'($urandom);
        cfg_ch    = 2'($urandom);
        cfg_limit = $urandom;
        cfg_mode  = 1'($urandom);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({clkout, tick, pending} !== {3'b000, 3'b000, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_outputs: clkout=%b tick=%b pending=%b required all 0", clkout, tick, pending);
        end
        for (int c = 0; c < 4; c++) begin
            cfg_ch = 2'(c);
            #1;
            n_checks++;
            if (cfg_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ready ch%0d: cfg_ready=%b required 1", c, cfg_ready);
            end
        end
        cfg_valid = 1'b0;
        en        = 3'b000;
        rst       = 1'b1;
        repeat (2) cyc();
    endtask

    task automatic test_toggle();
        bit et;
        bit ec;
        en = 3'b001;
        write_cfg(0, 3, 1'b0);
        n_checks++;
        if (pending[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle_pending_set: pending[0]=%b required 1", pending[0]);
        end
        cyc();
        n_checks++;
        if (pending[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL toggle_pending_clear: pending[0]=%b required 0", pending[0]);
        end
        for (int k = 1; k <= 18; k++) begin
            cyc();
            et = (k % 3) == 0;
            ec = ((k / 3) % 2) == 1;
            n_checks++;
            if (tick[0] !== et || clkout[0] !== ec) begin
                n_fail++;
                $display("FAIL toggle_wave k=%0d: tick=%b clkout=%b required %b %b", k, tick[0], clkout[0], et, ec);
            end
        end
    endtask

    task automatic test_pulse();
        bit et;
        int lim;
        en = 3'b011;
        write_cfg(1, 4, 1'b1);
        cyc();
        for (int k = 1; k <= 12; k++) begin
            cyc();
            et = (k % 4) == 0;
            n_checks++;
            if (tick[1] !== et || clkout[1] !== et) begin
                n_fail++;
                $display("FAIL pulse_wave k=%0d: tick=%b clkout=%b required %b %b", k, tick[1], clkout[1], et, et);
            end
        end
        write_cfg(1, 1, 1'b1);
        repeat (6) cyc();
        for (int k = 0; k < 6; k++) begin
            cyc();
            n_checks++;
            if (tick[1] !== 1'b1 || clkout[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL pulse_l1 k=%0d: tick=%b clkout=%b required 1 1", k, tick[1], clkout[1]);
            end
        end
        en  = 3'b111;
        lim = int'($urandom_range(2, 7));
        write_cfg(2, lim, 1'($urandom_range(0, 1)));
        for (int k = 0; k < 24; k++) begin
            cyc();
            n_checks++;
            if (clkout !== m_clk() || tick !== m_tick() || pending !== m_pend()) begin
                n_fail++;
                $display("FAIL pulse_rand k=%0d L=%0d: clkout=%b tick=%b pending=%b required %b %b %b",
                         k, lim, clkout, tick, pending, m_clk(), m_tick(), m_pend());
            end
        end
    endtask

    task automatic test_mid_update();
        int t;
        int held;
        write_cfg(0, 5, 1'b0);
        t = 0;
        while ((mq[0] || mage[0] != 1) && t < 30) begin
            cyc();
            t++;
        end
        n_checks++;
        if (t >= 30) begin
            n_fail++;
            $display("FAIL mid_sync: timed out waiting for position 1, waited=%0d required <30", t);
        end
        cfg_ch    = 2'd0;
        cfg_limit = 32'd2;
        cfg_mode  = 1'b0;
        cfg_valid = 1'b1;
        #1;
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_accept: cfg_ready=%b required 1", cfg_ready);
        end
        cyc();
        cfg_limit = 32'd7;
        held = 0;
        while (mq[0] && held < 10) begin
            n_checks++;
            if (cfg_ready !== 1'b0 || pending[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL mid_holdoff: cfg_ready=%b pending=%b required 0 1", cfg_ready, pending[0]);
            end
            cyc();
            held++;
        end
        cfg_valid = 1'b0;
        n_checks++;
        if (pending[0] !== 1'b0 || tick[0] !== 1'b1 || held != 3) begin
            n_fail++;
            $display("FAIL mid_apply: pending=%b tick=%b held=%0d required 0 1 3", pending[0], tick[0], held);
        end
        for (int k = 1; k <= 6; k++) begin
            cyc();
            n_checks++;
            if (tick[0] !== ((k % 2) == 0) || pending !== m_pend() || clkout !== m_clk()) begin
                n_fail++;
                $display("FAIL mid_period k=%0d: tick=%b pending=%b clkout=%b required %b %b %b",
                         k, tick[0], pending, clkout, (k % 2) == 0, m_pend(), m_clk());
            end
        end
    endtask

    task automatic test_stop_enable();
        int n;
        write_cfg(0, 0, 1'b0);
        n = 0;
        while (mq[0] && n < 20) begin
            cyc();
            n++;
        end
        for (int k = 0; k < 8; k++) begin
            cyc();
            n_checks++;
            if (clkout[0] !== 1'b0 || tick[0] !== 1'b0 || pending[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL stop_l0 k=%0d: clkout=%b tick=%b pending=%b required 0 0 0", k, clkout[0], tick[0], pending[0]);
            end
        end
        write_cfg(0, 6, 1'b0);
        repeat (10) cyc();
        en[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            n_checks++;
            if (clkout[0] !== 1'b0 || tick[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL stop_en k=%0d: clkout=%b tick=%b required 0 0", k, clkout[0], tick[0]);
            end
        end
        en[0] = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (tick[0] !== 1'b1 && n < 20);
        n_checks++;
        if (n != 6 || clkout[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_latency: first tick after %0d edges clkout=%b, required 6 and 1", n, clkout[0]);
        end
        cfg_ch    = 2'd3;
        cfg_limit = W'($urandom_range(1, 9));
        cfg_mode  = 1'($urandom_range(0, 1));
        cfg_valid = 1'b1;
        #1;
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_ready: cfg_ready=%b required 1", cfg_ready);
        end
        cyc();
        cfg_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (clkout !== m_clk() || tick !== m_tick() || pending !== m_pend()) begin
                n_fail++;
                $display("FAIL oor_nochange k=%0d: clkout=%b tick=%b pending=%b required %b %b %b",
                         k, clkout, tick, pending, m_clk(), m_tick(), m_pend());
            end
            cyc();
        end
    endtask

    task automatic test_async_reset();
        int n;
        en = 3'b111;
        write_cfg(2, 20, 1'b0);
        n = 0;
        while (mq[2] && n < 40) begin
            cyc();
            n++;
        end
        write_cfg(2, 3, 1'b0);
        n_checks++;
        if (pending[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_setup: pending[2]=%b required 1", pending[2]);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({clkout, tick, pending} !== {3'b000, 3'b000, 3'b000}) begin
            n_fail++;
            $display("FAIL areset_immediate: clkout=%b tick=%b pending=%b required all 0", clkout, tick, pending);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            n_checks++;
            if (clkout[2] !== 1'b0 || tick[2] !== 1'b0 || pending !== m_pend() || clkout !== m_clk()) begin
                n_fail++;
                $display("FAIL areset_after k=%0d: clkout=%b tick=%b pending=%b required %b %b %b",
                         k, clkout, tick, pending, m_clk(), m_tick(), m_pend());
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) en = 3'($urandom);
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_limit = W'($urandom_range(0, 6));
            cfg_mode  = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (cfg_ready !== model_ready()) begin
                n_fail++;
                $display("FAIL rand_ready k=%0d ch=%0d: cfg_ready=%b required %b", k, cfg_ch, cfg_ready, model_ready());
            end
            cyc();
            n_checks++;
            if (clkout !== m_clk() || tick !== m_tick() || pending !== m_pend()) begin
                n_fail++;
                $display("FAIL rand_out k=%0d: clkout=%b tick=%b pending=%b required %b %b %b",
                         k, clkout, tick, pending, m_clk(), m_tick(), m_pend());
            end
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        en        = 3'b000;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_limit = 32'd0;
        cfg_mode  = 1'b0;
        model_reset();
        test_reset();
        test_toggle();
        test_pulse();
        test_mid_update();
        test_stop_enable();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Bound the run in case a wait never completes
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cd_divider_bank.md
# cd_divider_bank

Multi-channel programmable clock divider for the CD subsystem. It generalises the single 50%-duty toggle counter to CHANNELS independent channels, each with its own divide value and mode (toggle or one-cycle pulse) and an enable. Divide values are updated glitch-free through a shadow-register handshake and take effect only at a period boundary. Outputs feed downstream clock-enable and strobe consumers in the same clock domain.

## Interface
- CHANNELS, 4, number of independent divider channels (1..16)
- WIDTH, CLK_MAX_WIDTH (CD parameter set, 32), counter and limit width
- CH_W, $clog2(CHANNELS) (min 1), width of channel select
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  CHANNELS  per-channel run enable
- cfg_valid  input  1  configuration write request
- cfg_ready  output  1  configuration write can be accepted (combinational)
- cfg_ch  input  CH_W  target channel of the write
- cfg_limit  input  WIDTH  new divide value L
- cfg_mode  input  1  0 = toggle (period 2L, 50% duty), 1 = pulse (one-cycle high every L)
- clkout  output  CHANNELS  divided output per channel, registered
- tick  output  CHANNELS  one-cycle strobe at each counter wrap, registered
- pending  output  CHANNELS  shadow value waiting to be applied

## Operation
- Per channel: active limit L, active mode M, counter c, shadow limit/mode, pending flag.
- Reset (rst low, async): c, L, M, shadows, pending, clkout, tick all 0. L = 0 means stopped.
- cfg_ready = 1 if cfg_ch >= CHANNELS, else !pending[cfg_ch]. Write accepted on an edge with cfg_valid & cfg_ready. Out-of-range channel: accepted, discarded, no state change.
- Accepted write: shadow <= {cfg_limit, cfg_mode}, pending <= 1.
- Apply (pending -> active): L <= shadow limit, M <= shadow mode, c <= 0, pending <= 0. Occurs on the wrap edge if running, or on the first edge after acceptance if stopped (en = 0 or L = 0).
- Running (en = 1, L != 0): wrap when c >= L-1 (L-1 computed in WIDTH bits). On wrap: c <= 0, tick <= 1. Otherwise c <= c+1, tick <= 0.
- Toggle mode: clkout toggles on each wrap. Pulse mode: clkout <= wrap condition, identical to tick.
- Apply edge with mode change: clkout <= 0, tick still asserts for the wrap. Without a mode change, clkout behaves as a normal wrap.
- en = 0: c <= 0, clkout <= 0, tick <= 0. Pending apply still proceeds. en re-assert restarts from c = 0.
- L = 0 with en = 1: same as en = 0 (outputs held low).
- L = 1: toggle gives clk/2. Pulse gives clkout and tick constantly high.
- Channels are fully independent. Simultaneous writes to different channels are not possible (one port). A write and an apply on the same channel in the same cycle cannot occur, because ready is low while pending.

## Timing
- Write acceptance to pending high: 1 edge. Earliest apply when stopped: the following edge.
- Running channel: new L is visible from the first edge after the current period's wrap. The old period always completes.
- tick and clkout change on the same edge, the one where c was L-1. No combinational path from en or cfg to clkout or tick.
- Reset asserted mid-period: all outputs go to 0 immediately. Pending writes are lost. After release, a channel stays stopped until written.

## Test plan
- Reset: drive rst low with all inputs random -> clkout = tick = pending = 0. cfg_ready = 1 on every channel.
- Toggle, ch0, L = 3, en = 1 -> pending high for 1 cycle. clkout period is 6 cycles (3 high, 3 low). tick pulses every 3 cycles.
- Pulse, ch1, L = 4 -> clkout equals tick: one cycle high every 4. L = 1 -> constant high.
- Mid-period update: ch0 running at L = 5, write L = 2 when c = 1 -> cfg_ready[ch0] low until the wrap at c = 4. A second write in that window is held off. The next period is 2 cycles.
- Stop and enable: write L = 0 -> clkout and tick are 0 from the next edge. Drop en while L = 6 -> outputs 0. Re-raise en -> first tick 6 cycles later. Write to cfg_ch = CHANNELS -> accepted, no channel changes.
- Async reset mid-operation, with pending on ch2 -> all outputs 0 without waiting for a clock edge. ch2 stays stopped after release.
